// File: rtl/mem_access_stage.sv
// MEM stage: turns each load/store into one req/ack transaction on the data-memory
// port and holds the pipeline (mem_stall) until the transaction has finished.
// All state advances on the falling clock edge, in step with the pipeline registers.
module mem_access_stage #(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRead_out_pipe_3,
  input  logic              memWrite_out_pipe_3,
  input  logic [DATA_W-1:0] aluResult_out_pipe_3,
  input  logic [DATA_W-1:0] write_data_out_pipe_3,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] data_mem_read_data,
  output logic              mem_stall,
  output logic              mem_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Registered view of the outstanding memory request.
  typedef struct packed {
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;

  state_t            state_q, state_d;
  dmem_req_t         rq_q, rq_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              err_q, err_d;
  logic              op;

  // A store wins when both read and write are flagged, since we follows memWrite.
  assign op = memRead_out_pipe_3 | memWrite_out_pipe_3;

  // Next-state and next-register values; every register holds unless an event moves it.
  always_comb begin
    state_d = state_q;
    rq_d    = rq_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (op) begin
          state_d = WAIT;
          rq_d    = '{req: 1'b1, we: memWrite_out_pipe_3,
                      addr: aluResult_out_pipe_3, wdata: write_data_out_pipe_3};
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // An ack arriving on the timeout cycle still counts as a success.
        if (dmem_ack) begin
          state_d = DONE;
          rq_d.req = 1'b0;
          if (!rq_q.we) rd_d = dmem_rdata;
        end else if (cnt_q == CW'(MAX_WAIT)) begin
          state_d  = DONE;
          rq_d.req = 1'b0;
          err_d    = 1'b1;
          if (!rq_q.we) rd_d = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, falling-edge with immediate reset.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rq_q    <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rq_q    <= rq_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  assign dmem_req           = rq_q.req;
  assign dmem_we            = rq_q.we;
  assign dmem_addr          = rq_q.addr;
  assign dmem_wdata         = rq_q.wdata;
  assign data_mem_read_data = rd_q;
  assign mem_err            = err_q;
  // Stall from the moment a memory op shows up until the response is in; DONE releases.
  assign mem_stall          = ((state_q == IDLE) & op) | (state_q == WAIT);

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then random load/store traffic,
// with the bench acting as the data memory and predicting results per transaction.
module tb_mem_access_stage;
  localparam int DW = 16;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_i = 1'b0, wr_i = 1'b0;
  logic [DW-1:0] addr_i = '0, wd_i = '0;
  logic          req, we;
  logic [DW-1:0] a_o, wd_o;
  logic          ack = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] mrd;
  logic          stall, err;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_rd = '0;
  logic          exp_err = 1'b0;

  mem_access_stage #(.DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .memRead_out_pipe_3(rd_i), .memWrite_out_pipe_3(wr_i),
    .aluResult_out_pipe_3(addr_i), .write_data_out_pipe_3(wd_i),
    .dmem_req(req), .dmem_we(we), .dmem_addr(a_o), .dmem_wdata(wd_o),
    .dmem_ack(ack), .dmem_rdata(rdata),
    .data_mem_read_data(mrd), .mem_stall(stall), .mem_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Cycles with no memory op; random acks must be ignored and outputs hold.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rd_i = 1'b0; wr_i = 1'b0;
      ack = 1'($urandom_range(0, 1)); rdata = DW'($urandom);
      @(posedge clk);
      chk("idle_stall", stall, 0);
      chk("idle_req", req, 0);
      chk("idle_rd", mrd, exp_rd);
      chk("idle_err", err, exp_err);
      @(negedge clk); #1;
    end
    ack = 1'b0;
  endtask

  // One transaction. k = WAIT cycle in which the memory acks (1-based); k = 0 never acks.
  // Called and returning at negedge+1 with the DUT idle.
  task automatic do_op(input bit r, input bit w, input logic [DW-1:0] ad,
                       input logic [DW-1:0] wd, input int k, input logic [DW-1:0] rv);
    int stalls = 0;
    bit done = 1'b0;
    int exp_stalls = (k == 0) ? MW + 2 : k + 1;
    rd_i = r; wr_i = w; addr_i = ad; wd_i = wd;
    for (int c = 0; c < MW + 8 && !done; c++) begin
      ack = (k != 0 && c == k);
      rdata = ack ? rv : DW'($urandom);
      @(posedge clk);
      if (stall) begin
        stalls++;
        if (c >= 1) begin
          chk("wait_req", req, 1);
          chk("wait_we", we, w);
          chk("wait_addr", a_o, ad);
          chk("wait_wdata", wd_o, wd);
          chk("wait_rd_hold", mrd, exp_rd);
        end else begin
          chk("first_req", req, 0);
        end
      end else begin
        done = 1'b1;
        chk("done_req", req, 0);
      end
      @(negedge clk); #1;
      ack = 1'b0;
    end
    chk("op_done", done, 1);
    chk("stall_cycles", stalls, exp_stalls);
    if (k == 0) exp_err = 1'b1;
    if (!w) exp_rd = (k == 0) ? '1 : rv;
    chk("op_rd", mrd, exp_rd);
    chk("op_err", err, exp_err);
    rd_i = 1'b0; wr_i = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_req", req, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", a_o, 0);
    chk("rst_wdata", wd_o, 0);
    chk("rst_rd", mrd, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
    @(negedge clk); @(negedge clk); #1;
    rst_n = 1'b1;

    // Directed scenarios.
    do_op(1, 0, 16'h0040, 16'h0000, 2, 16'hBEEF);
    do_op(0, 1, 16'h0010, 16'h1234, 1, 16'h5555);
    idle_cycles(5);
    do_op(1, 1, 16'h0020, 16'hA5A5, 3, 16'h7777);     // both set -> store
    do_op(1, 0, 16'h0030, 16'h0000, MW + 1, 16'hC0DE); // ack on timeout cycle wins
    do_op(1, 0, 16'h0001, 16'h0000, 1, 16'h1111);      // back-to-back loads
    do_op(1, 0, 16'h0002, 16'h0000, 4, 16'h2222);
    do_op(1, 0, 16'h0050, 16'h0000, 0, 16'h0000);      // timeout
    do_op(1, 0, 16'h0060, 16'h0000, 2, 16'h3C3C);      // still works afterward
    idle_cycles(2);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      bit r, w;
      int k;
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MW + 1));
      do_op(r, w, DW'($urandom), DW'($urandom), k, DW'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end

    // Reset in the middle of a load, then a stray ack.
    rd_i = 1'b1; addr_i = 16'h0055;
    @(posedge clk);
    @(negedge clk); #1;
    @(posedge clk);
    chk("pre_rst_req", req, 1);
    @(negedge clk); #1;
    rd_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_addr", a_o, 0);
    chk("mid_rst_wdata", wd_o, 0);
    chk("mid_rst_rd", mrd, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_stall", stall, 0);
    exp_rd = '0; exp_err = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    ack = 1'b1; rdata = 16'hDEAD;
    @(posedge clk);
    chk("stray_stall", stall, 0);
    @(negedge clk); #1;
    ack = 1'b0;
    @(posedge clk);
    chk("stray_req", req, 0);
    chk("stray_rd", mrd, 0);
    @(negedge clk); #1;
    do_op(1, 0, 16'h0077, 16'h0000, 2, 16'h4242);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
